skid_buffer_async_rst_n: RTL

Two-entry valid/ready register slice. It sits between a producer and a consumer, breaks every combinational path between them (data, valid and ready), and sustains one transfer per clock under any backpressure pattern. It is the pipeline stage used wherever a plain enabled register would otherwise need its enable driven combinationally from downstream ready.

---
 rtl/skid_buffer_async_rst_n.sv | 98 +++++++++
 1 files changed

// File: rtl/skid_buffer_async_rst_n.sv
// ============================================================================
// Module   : skid_buffer_async_rst_n
// Purpose  : Two-entry valid/ready register slice; every output is decoded
//            from registered state, so no input reaches an output directly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buffer_async_rst_n #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_next;
  logic [WIDTH-1:0] w_skid_next;
  logic             w_in_fire;
  logic             w_out_fire;

  assign out_valid  = (r_state != EMPTY);
  assign in_ready   = (r_state != FULL);
  assign count      = r_state;
  assign out_data   = r_main;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (flush) begin
      // Data registers are left alone; only occupancy is cleared.
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_main_next  = in_data;
            w_state_next = ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_next  = in_data;
          end else if (w_in_fire) begin
            w_skid_next  = in_data;
            w_state_next = FULL;
          end else if (w_out_fire) begin
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_main_next  = r_skid;
            w_state_next = ONE;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire
